// File: rtl/pipeline_hazard_ctl_if.sv
// Control bundle between the BRISC pipeline datapath and its hazard controller.
// The datapath side drives decode/execute status; the controller returns the
// pipeline-register enables, bubbles and status.
interface pipeline_hazard_ctl_if #(
    parameter int CNT_W = 16
);
    logic             load_done;
    logic             step_mode;
    logic             step_btn;
    logic             id_valid;
    logic [3:0]       id_a_addr;
    logic [3:0]       id_b_addr;
    logic             id_uses_a;
    logic             id_uses_b;
    logic             id_reg_write;
    logic [3:0]       id_c_addr;
    logic             ex_jump_en;
    logic             pc_en;
    logic             ifid_hold;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             running;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output load_done, step_mode, step_btn, id_valid, id_a_addr, id_b_addr,
               id_uses_a, id_uses_b, id_reg_write, id_c_addr, ex_jump_en,
        input  pc_en, ifid_hold, idex_bubble, ifid_flush, running, stall_count
    );

    modport slave (
        input  load_done, step_mode, step_btn, id_valid, id_a_addr, id_b_addr,
               id_uses_a, id_uses_b, id_reg_write, id_c_addr, ex_jump_en,
        output pc_en, ifid_hold, idex_bubble, ifid_flush, running, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctl.sv
// Hazard / sequencing controller for the 4-stage BRISC pipeline.
// Tracks in-flight register writes, stalls decode on RAW hazards, flushes the
// front end on taken jumps, gates issue on program load and supports single-step.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_LOAD  | program memory not loaded, nothing issues
//   S_RUN   | free-running issue
//   S_STEP  | issue only while a step token is held
//   S_FLUSH | front end being flushed after a taken jump
module pipeline_hazard_ctl #(
    parameter int DEPTH        = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    pipeline_hazard_ctl_if.slave bus
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    // Counter holds the FLUSH-state cycles still to go, including the current one.
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [DEPTH-1:0]       r_sb_vld;
    logic [DEPTH-1:0][3:0]  r_sb_addr;
    logic [1:0]             r_flush_cnt;
    logic                   r_btn_s1;
    logic                   r_btn_s2;
    logic                   r_btn_s3;
    logic                   r_tok;
    logic [CNT_W-1:0]       r_stall_cnt;

    logic                   w_match_a;
    logic                   w_match_b;
    logic                   w_hazard;
    logic                   w_active;
    logic                   w_jump;
    logic                   w_issue;
    logic                   w_drop;
    logic                   w_btn_edge;
    state_t                 w_resume;

    // Scoreboard lookup for both decode source operands.
    always_comb begin
        w_match_a = 1'b0;
        w_match_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_sb_vld[i] && (r_sb_addr[i] == bus.id_a_addr)) w_match_a = 1'b1;
            if (r_sb_vld[i] && (r_sb_addr[i] == bus.id_b_addr)) w_match_b = 1'b1;
        end
    end

    assign w_hazard   = bus.id_valid & ((bus.id_uses_a & w_match_a) |
                                        (bus.id_uses_b & w_match_b));
    assign w_active   = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_jump     = w_active & bus.ex_jump_en;
    assign w_issue    = ((r_state == S_RUN) || ((r_state == S_STEP) && r_tok)) &
                        ~w_hazard & ~bus.ex_jump_en;
    assign w_drop     = (r_state != S_LOAD) & ~bus.load_done;
    assign w_btn_edge = r_btn_s2 & ~r_btn_s3;
    assign w_resume   = bus.step_mode ? S_STEP : S_RUN;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_LOAD;
        else     r_state <= w_next;
    end

    // Next-state and pipeline control outputs.
    always_comb begin
        w_next          = r_state;
        bus.pc_en       = w_issue;
        bus.ifid_hold   = ~w_issue;
        bus.idex_bubble = ~w_issue;
        bus.ifid_flush  = 1'b0;
        bus.running     = (r_state != S_LOAD);

        case (r_state)
            S_LOAD: begin
                if (bus.load_done) w_next = w_resume;
            end
            S_RUN, S_STEP: begin
                // A single-cycle flush is just the jump cycle itself.
                if (bus.ex_jump_en && (FLUSH_CYCLES > 1)) w_next = S_FLUSH;
                else                                      w_next = w_resume;
            end
            S_FLUSH: begin
                if (r_flush_cnt <= 2'd1) w_next = w_resume;
            end
            default: w_next = S_LOAD;
        endcase

        if (w_drop) w_next = S_LOAD;

        if ((r_state == S_FLUSH) || w_jump) begin
            bus.pc_en       = 1'b1;
            bus.ifid_hold   = 1'b0;
            bus.idex_bubble = 1'b1;
            bus.ifid_flush  = 1'b1;
        end
    end

    // Flush cycle counter, loaded on the jump cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_flush_cnt <= 2'd0;
        end else if (w_jump) begin
            r_flush_cnt <= FLUSH_LOAD;
        end else if ((r_state == S_FLUSH) && (r_flush_cnt != 2'd0)) begin
            r_flush_cnt <= r_flush_cnt - 2'd1;
        end
    end

    // In-flight write scoreboard: shifts every cycle, cleared when load drops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sb_vld  <= '0;
            r_sb_addr <= '0;
        end else if (w_drop) begin
            r_sb_vld  <= '0;
        end else begin
            r_sb_vld[0]  <= w_issue & bus.id_reg_write;
            r_sb_addr[0] <= bus.id_c_addr;
            for (int i = 1; i < DEPTH; i++) begin
                r_sb_vld[i]  <= r_sb_vld[i-1];
                r_sb_addr[i] <= r_sb_addr[i-1];
            end
        end
    end

    // Step button synchronizer plus edge-detect history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_btn_s3 <= 1'b0;
        end else begin
            r_btn_s1 <= bus.step_btn;
            r_btn_s2 <= r_btn_s1;
            r_btn_s3 <= r_btn_s2;
        end
    end

    // Step token: any number of edges before an issue collapse to one token.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tok <= 1'b0;
        end else if (w_drop) begin
            r_tok <= 1'b0;
        end else if (w_btn_edge) begin
            r_tok <= 1'b1;
        end else if ((r_state == S_STEP) && w_issue) begin
            r_tok <= 1'b0;
        end
    end

    // Saturating RAW stall cycle counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_active && w_hazard && !bus.ex_jump_en && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Bench for pipeline_hazard_ctl: expected control outputs are queued as each
// cycle's stimulus is applied and compared at the following falling edge.
// A second instance with a deep scoreboard exercises stall counter saturation.
module tb_pipeline_hazard_ctl;

    localparam logic [4:0] E_LOAD = 5'b01100;  // {pc_en,hold,bubble,flush,running}
    localparam logic [4:0] E_ISS  = 5'b10001;
    localparam logic [4:0] E_STL  = 5'b01101;
    localparam logic [4:0] E_FLS  = 5'b10111;

    logic CLK;
    logic RST;

    pipeline_hazard_ctl_if #(.CNT_W(16)) m_if ();
    pipeline_hazard_ctl_if #(.CNT_W(16)) s_if ();

    pipeline_hazard_ctl #(.DEPTH(2), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (m_if)
    );

    pipeline_hazard_ctl #(.DEPTH(15), .FLUSH_CYCLES(2), .CNT_W(16)) u_sat (
        .CLK (CLK),
        .RST (RST),
        .bus (s_if)
    );

    logic [4:0] m_outs;
    assign m_outs = {m_if.pc_en, m_if.ifid_hold, m_if.idex_bubble, m_if.ifid_flush, m_if.running};

    int         n_chk  = 0;
    int         n_pass = 0;
    string      tag_q[$];
    logic [4:0] exp_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Queue this cycle's expectation, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [4:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            string      t;
            logic [4:0] e;
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk(t, {27'd0, m_outs}, {27'd0, e});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        m_if.load_done = 0; m_if.step_mode = 0; m_if.step_btn = 0; m_if.id_valid = 0;
        m_if.id_a_addr = 0; m_if.id_b_addr = 0; m_if.id_uses_a = 0; m_if.id_uses_b = 0;
        m_if.id_reg_write = 0; m_if.id_c_addr = 0; m_if.ex_jump_en = 0;
        s_if.load_done = 0; s_if.step_mode = 0; s_if.step_btn = 0; s_if.id_valid = 0;
        s_if.id_a_addr = 0; s_if.id_b_addr = 0; s_if.id_uses_a = 0; s_if.id_uses_b = 0;
        s_if.id_reg_write = 0; s_if.id_c_addr = 0; s_if.ex_jump_en = 0;
        RST = 0;
        #2 RST = 1;
        #1;
        chk("reset_outs", {27'd0, m_outs}, {27'd0, E_LOAD});
        chk("reset_cnt", {16'd0, m_if.stall_count}, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 0;

        // Program load gating
        repeat (10) cyc("load_wait", E_LOAD);
        m_if.load_done = 1;
        cyc("load_rise", E_LOAD);
        m_if.id_valid = 1;
        repeat (3) cyc("run_free", E_ISS);

        // RAW on r3: two stall cycles
        m_if.id_reg_write = 1; m_if.id_c_addr = 3;
        m_if.id_uses_a = 1; m_if.id_a_addr = 1; m_if.id_uses_b = 1; m_if.id_b_addr = 2;
        cyc("raw_wr", E_ISS);
        m_if.id_reg_write = 0; m_if.id_a_addr = 3; m_if.id_uses_b = 0; m_if.id_b_addr = 0;
        cyc("raw_stall1", E_STL);
        cyc("raw_stall2", E_STL);
        cyc("raw_issue", E_ISS);
        chk("raw_cnt", {16'd0, m_if.stall_count}, 32'd2);

        // Same sequence but A replaced by an immediate: no stall
        m_if.id_reg_write = 1; m_if.id_c_addr = 3; m_if.id_a_addr = 1;
        cyc("imm_wr", E_ISS);
        m_if.id_reg_write = 0; m_if.id_a_addr = 3; m_if.id_uses_a = 0;
        cyc("imm_issue1", E_ISS);
        cyc("imm_issue2", E_ISS);
        chk("imm_cnt", {16'd0, m_if.stall_count}, 32'd2);

        // Jump with a hazard present on the jump cycle
        m_if.id_reg_write = 1; m_if.id_c_addr = 4;
        cyc("jmp_wr", E_ISS);
        m_if.id_reg_write = 0; m_if.id_uses_a = 1; m_if.id_a_addr = 4; m_if.ex_jump_en = 1;
        cyc("jmp_cycle", E_FLS);
        m_if.ex_jump_en = 0;
        cyc("jmp_flush", E_FLS);
        cyc("jmp_resume", E_ISS);
        chk("jmp_cnt", {16'd0, m_if.stall_count}, 32'd2);
        m_if.id_uses_a = 0;

        // Single step: no issue without a token; bouncing press gives one issue
        m_if.step_mode = 1;
        cyc("step_enter", E_ISS);
        repeat (4) cyc("step_idle", E_STL);
        for (int k = 0; k < 8; k++) begin
            m_if.ex_jump_en = 1;
            m_if.step_btn   = (k == 1 || k == 3) ? 1'b0 : 1'b1;
            cyc("step_bounce", E_FLS);
        end
        m_if.ex_jump_en = 0;
        cyc("step_issue", E_ISS);
        repeat (3) cyc("step_after", E_STL);
        m_if.step_btn = 0;

        // Load drop with r5 in flight, then immediate reload reading r5
        m_if.step_mode = 0;
        cyc("run_back", E_STL);
        m_if.id_reg_write = 1; m_if.id_c_addr = 5;
        cyc("drop_wr", E_ISS);
        m_if.load_done = 0;
        cyc("drop_cycle", E_ISS);
        m_if.load_done = 1; m_if.id_reg_write = 0;
        cyc("reload", E_LOAD);
        m_if.id_uses_a = 1; m_if.id_a_addr = 5;
        cyc("reload_r5", E_ISS);
        chk("drop_cnt", {16'd0, m_if.stall_count}, 32'd2);
        m_if.id_uses_a = 0; m_if.id_valid = 0;

        // Asynchronous reset in the middle of a flush
        m_if.ex_jump_en = 1;
        cyc("rst_jump", E_FLS);
        m_if.ex_jump_en = 0;
        chk("rst_pre_flush", {27'd0, m_outs}, {27'd0, E_FLS});
        #2 RST = 1;
        #1;
        chk("rst_async_outs", {27'd0, m_outs}, {27'd0, E_LOAD});
        chk("rst_async_cnt", {16'd0, m_if.stall_count}, 32'd0);
        @(posedge CLK);
        #1 RST = 0;

        // Stall counter saturation: 0x10000 hazard cycles on the deep instance
        s_if.load_done = 1; s_if.id_valid = 1;
        @(posedge CLK);
        #1;
        for (int b = 0; b < 4370; b++) begin
            s_if.id_uses_a = 0; s_if.id_reg_write = 1; s_if.id_c_addr = 9; s_if.id_a_addr = 9;
            @(posedge CLK);
            #1;
            s_if.id_reg_write = 0; s_if.id_uses_a = 1;
            repeat ((b < 4369) ? 15 : 1) begin
                @(posedge CLK);
                #1;
            end
            if (b == 0) chk("sat_first", {16'd0, s_if.stall_count}, 32'd15);
        end
        chk("sat_hold", {16'd0, s_if.stall_count}, 32'h0000FFFF);
        chk("sat_running", {31'd0, s_if.running}, 32'd1);

        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
